grid_cursor: RTL

//  Parametrised successor to the 4x4 card cursor. Tracks the player's cell on a COLS x ROWS board.

---
 rtl/grid_pkg.sv | 32 +++
 rtl/grid_cursor_if.sv | 41 ++++
 rtl/axis_stepper.sv | 62 ++++++
 rtl/grid_cursor.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/grid_pkg.sv
// -----------------------------------------------------------------------------
// grid_pkg
// Shared types and helpers for the grid cursor:
//   cursor_state_t : move FSM states (IDLE, DELAY, REPEAT)
//   dir_t          : resolved direction vector (up, down, left, right)
//   coord_w(n)     : coordinate width for an axis of n cells, at least 1 bit
//   max_int(a, b)  : larger of two integers, used for counter sizing
// -----------------------------------------------------------------------------
package grid_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } cursor_state_t;

    typedef struct packed {
        logic up;
        logic down;
        logic left;
        logic right;
    } dir_t;

    function automatic int coord_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/grid_cursor_if.sv
// -----------------------------------------------------------------------------
// grid_cursor_if
// Bundles the debounced direction inputs and the cursor outputs.
//   up/down/left/right : direction requests (driven by master)
//   home               : return to (0,0), present only with GRID_CURSOR_HOME_EN
//   locationX/Y        : current cell (driven by slave = grid_cursor)
//   moved / bump       : one-cycle status pulses (driven by slave)
// Parameters XW/YW must match the cursor's coordinate widths.
// -----------------------------------------------------------------------------
interface grid_cursor_if #(
    parameter int XW = 2,
    parameter int YW = 2
);
    logic          up;
    logic          down;
    logic          left;
    logic          right;
`ifdef GRID_CURSOR_HOME_EN
    logic          home;
`endif
    logic [XW-1:0] locationX;
    logic [YW-1:0] locationY;
    logic          moved;
    logic          bump;

    modport master (
`ifdef GRID_CURSOR_HOME_EN
        output home,
`endif
        output up, down, left, right,
        input  locationX, locationY, moved, bump
    );

    modport slave (
`ifdef GRID_CURSOR_HOME_EN
        input  home,
`endif
        input  up, down, left, right,
        output locationX, locationY, moved, bump
    );
endinterface

// File: rtl/axis_stepper.sv
// -----------------------------------------------------------------------------
// axis_stepper
// Combinational next-position logic for one axis of N cells.
//   pos      : current coordinate
//   inc/dec  : step toward N-1 / toward 0 (both or neither = no move)
//   step     : the FSM is issuing a move this edge
//   next_pos : coordinate after this edge
//   blocked  : clamp mode only, the requested move hit an edge
// WRAP=1 wraps around the edge, WRAP=0 holds the coordinate and flags blocked.
// -----------------------------------------------------------------------------
module axis_stepper
    import grid_pkg::*;
#(
    parameter int N    = 4,
    parameter int WRAP = 1,
    parameter int W    = coord_w(N)
) (
    input  logic [W-1:0] pos,
    input  logic         inc,
    input  logic         dec,
    input  logic         step,
    output logic [W-1:0] next_pos,
    output logic         blocked
);
    localparam logic [W-1:0] LAST = W'(N - 1);
    localparam logic [W-1:0] ONE  = W'(1'b1);

    // Next coordinate; ">=" on LAST keeps non-power-of-two axes inside range.
    always_comb begin
        next_pos = pos;
        blocked  = 1'b0;
        if (step && (inc != dec)) begin
            if (inc) begin
                if (pos >= LAST) begin
                    if (WRAP != 0) begin
                        next_pos = '0;
                    end else begin
                        next_pos = LAST;
                        blocked  = 1'b1;
                    end
                end else begin
                    next_pos = pos + ONE;
                end
            end else begin
                if (pos == '0) begin
                    if (WRAP != 0) begin
                        next_pos = LAST;
                    end else begin
                        next_pos = pos;
                        blocked  = 1'b1;
                    end
                end else if (pos > LAST) begin
                    next_pos = LAST;
                end else begin
                    next_pos = pos - ONE;
                end
            end
        end else begin
            next_pos = pos;
        end
    end
endmodule

// File: rtl/grid_cursor.sv
// -----------------------------------------------------------------------------
// grid_cursor
// Tracks the player's cell on a COLS x ROWS board with edge-triggered moves,
// hold-to-auto-repeat, diagonal moves and wrap/clamp edge handling.
//   clk   : clock, all logic on posedge
//   reset : synchronous, active-low
//   bus   : grid_cursor_if slave (directions in; locationX/Y, moved, bump out)
// Optional feature macro: GRID_CURSOR_HOME_EN adds the home input.
// All outputs are registered.
// -----------------------------------------------------------------------------
module grid_cursor
    import grid_pkg::*;
#(
    parameter int COLS         = 4,
    parameter int ROWS         = 4,
    parameter int WRAP         = 1,
    parameter int REPEAT_DELAY = 8,
    parameter int REPEAT_RATE  = 4
) (
    input  logic         clk,
    input  logic         reset,
    grid_cursor_if.slave bus
);
    localparam int XW = coord_w(COLS);
    localparam int YW = coord_w(ROWS);
    localparam int CW = $clog2(max_int(REPEAT_DELAY, REPEAT_RATE) + 1);
    localparam logic [CW-1:0] DELAY_LAST = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] RATE_LAST  = CW'(REPEAT_RATE - 1);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1'b1);

    cursor_state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    dir_t          dir_q, dir_s;
    logic [XW-1:0] loc_x_q, loc_x_d, next_x_s;
    logic [YW-1:0] loc_y_q, loc_y_d, next_y_s;
    logic          moved_q, moved_d, bump_q, bump_d;
    logic          blk_x_s, blk_y_s, step_s, active_s;

    // Opposing requests cancel only their own axis.
    always_comb begin
        dir_s.up    = bus.up & ~bus.down;
        dir_s.down  = bus.down & ~bus.up;
        dir_s.left  = bus.left & ~bus.right;
        dir_s.right = bus.right & ~bus.left;
        active_s    = |dir_s;
    end

    // Move FSM: first press steps at once, a hold repeats after DELAY then every RATE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        step_s  = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (active_s) begin
                    step_s  = 1'b1;
                    state_d = DELAY;
                end else begin
                    state_d = IDLE;
                end
            end
            DELAY: begin
                if (!active_s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (dir_s != dir_q) begin
                    step_s = 1'b1;
                    cnt_d  = '0;
                end else if (cnt_q == DELAY_LAST) begin
                    step_s  = 1'b1;
                    cnt_d   = '0;
                    state_d = REPEAT;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            REPEAT: begin
                if (!active_s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (dir_s != dir_q) begin
                    step_s  = 1'b1;
                    cnt_d   = '0;
                    state_d = DELAY;
                end else if (cnt_q == RATE_LAST) begin
                    step_s = 1'b1;
                    cnt_d  = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
`ifdef GRID_CURSOR_HOME_EN
        // Home drops back to IDLE so a still-held direction counts as a new press.
        if (bus.home) begin
            state_d = IDLE;
            cnt_d   = '0;
            step_s  = 1'b0;
        end else begin
            state_d = state_d;
        end
`endif
    end

    axis_stepper #(.N(COLS), .WRAP(WRAP), .W(XW)) u_step_x (
        .pos      (loc_x_q),
        .inc      (dir_s.right),
        .dec      (dir_s.left),
        .step     (step_s),
        .next_pos (next_x_s),
        .blocked  (blk_x_s)
    );

    axis_stepper #(.N(ROWS), .WRAP(WRAP), .W(YW)) u_step_y (
        .pos      (loc_y_q),
        .inc      (dir_s.down),
        .dec      (dir_s.up),
        .step     (step_s),
        .next_pos (next_y_s),
        .blocked  (blk_y_s)
    );

    // Next location and status pulses; moved and bump can both fire on a diagonal.
    always_comb begin
        loc_x_d = next_x_s;
        loc_y_d = next_y_s;
        moved_d = (next_x_s != loc_x_q) || (next_y_s != loc_y_q);
        bump_d  = blk_x_s | blk_y_s;
`ifdef GRID_CURSOR_HOME_EN
        if (bus.home) begin
            loc_x_d = '0;
            loc_y_d = '0;
            moved_d = (loc_x_q != '0) || (loc_y_q != '0);
            bump_d  = 1'b0;
        end else begin
            bump_d = blk_x_s | blk_y_s;
        end
`endif
    end

    // State, counter, last direction and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dir_q   <= '0;
            loc_x_q <= '0;
            loc_y_q <= '0;
            moved_q <= 1'b0;
            bump_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_s;
            loc_x_q <= loc_x_d;
            loc_y_q <= loc_y_d;
            moved_q <= moved_d;
            bump_q  <= bump_d;
        end
    end

    assign bus.locationX = loc_x_q;
    assign bus.locationY = loc_y_q;
    assign bus.moved     = moved_q;
    assign bus.bump      = bump_q;
endmodule
